// File: rtl/sig_force_pkg.sv
// rtl/sig_force_pkg.sv - shared types and constants for the sig_force channel override block
// Optional statistics are enabled with SIG_FORCE_STATS_EN.
package sig_force_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TIMED = 2'd1,
    HOLD  = 2'd2
  } chan_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/sig_force_if.sv
// rtl/sig_force_if.sv - force/release request bus for sig_force
// The master issues force and release requests; the slave (sig_force) returns frc_ready.
interface sig_force_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  localparam int IDX_W = $clog2(CHANNELS) + 1;

  logic             frc_valid;
  logic             frc_ready;
  logic [IDX_W-1:0] frc_chan;
  logic [WIDTH-1:0] frc_value;
  logic [CNT_W-1:0] frc_cycles;
  logic             rel_valid;
  logic [IDX_W-1:0] rel_chan;

  modport master (
    output frc_valid, frc_chan, frc_value, frc_cycles, rel_valid, rel_chan,
    input  frc_ready
  );

  modport slave (
    input  frc_valid, frc_chan, frc_value, frc_cycles, rel_valid, rel_chan,
    output frc_ready
  );
endinterface

// File: rtl/sig_force_chan.sv
// rtl/sig_force_chan.sv - one channel: IDLE/TIMED/HOLD state, duration counter and output register
// SIG_FORCE_STATS_EN adds a saturating count of output changes.
module sig_force_chan
  import sig_force_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              frc_hit,
  input  logic [WIDTH-1:0]  frc_value,
  input  logic [CNT_W-1:0]  frc_cycles,
  input  logic              rel_hit,
  output logic [WIDTH-1:0]  out_data,
  output logic              forced
`ifdef SIG_FORCE_STATS_EN
  ,
  output logic [STAT_W-1:0] chg_count
`endif
);

  chan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] val_q, val_nxt;
  logic [WIDTH-1:0] out_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      val_q    <= '0;
      out_data <= '0;
      forced   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      val_q    <= val_nxt;
      out_data <= out_nxt;
      forced   <= (state_nxt != IDLE);
    end
  end

  // Release outranks force; the top already refuses a force that collides with a release.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    val_nxt   = val_q;
    if (rel_hit) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (frc_hit) begin
      val_nxt   = frc_value;
      cnt_nxt   = frc_cycles;
      state_nxt = (frc_cycles == '0) ? HOLD : TIMED;
    end else begin
      case (state)
        TIMED: begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_nxt = (state_nxt != IDLE) ? val_nxt : in_data;
  end

`ifdef SIG_FORCE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_count <= '0;
    end else if ((out_nxt != out_data) && (chg_count != {STAT_W{1'b1}})) begin
      chg_count <= chg_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/sig_force.sv
// rtl/sig_force.sv - per-channel output override with timed/held forces and releases
// Request decode, release-wins arbitration and sticky err; SIG_FORCE_STATS_EN adds chg_count.
module sig_force
  import sig_force_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  sig_force_if.slave                   bus,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic [CHANNELS-1:0]          forced,
  output logic                         err
`ifdef SIG_FORCE_STATS_EN
  ,
  output logic [CHANNELS*STAT_W-1:0]   chg_count
`endif
);

  localparam int IDX_W = $clog2(CHANNELS) + 1;

  logic frc_acc;
  logic bad_idx;

  assign bus.frc_ready = !rst && !(bus.rel_valid && (bus.rel_chan == bus.frc_chan));
  assign frc_acc       = bus.frc_valid && bus.frc_ready;

  // Out-of-range indices match no channel below, so they only raise err.
  assign bad_idx = (frc_acc && (bus.frc_chan >= IDX_W'(CHANNELS))) ||
                   (bus.rel_valid && (bus.rel_chan >= IDX_W'(CHANNELS)));

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bad_idx) begin
      err <= 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sig_force_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data[c*WIDTH +: WIDTH]),
      .frc_hit    (frc_acc && (bus.frc_chan == IDX_W'(c))),
      .frc_value  (bus.frc_value),
      .frc_cycles (bus.frc_cycles),
      .rel_hit    (bus.rel_valid && (bus.rel_chan == IDX_W'(c))),
      .out_data   (out_data[c*WIDTH +: WIDTH]),
      .forced     (forced[c])
`ifdef SIG_FORCE_STATS_EN
      ,
      .chg_count  (chg_count[c*STAT_W +: STAT_W])
`endif
    );
  end

endmodule

// File: tb/tb_sig_force.sv
// tb/tb_sig_force.sv - directed self-checking bench for sig_force (CHANNELS=4, WIDTH=1)
// Compiling with SIG_FORCE_STATS_EN also exercises chg_count.
module tb_sig_force;

  localparam int WIDTH    = 1;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       forced;
  logic                      err;
`ifdef SIG_FORCE_STATS_EN
  logic [CHANNELS*16-1:0]    chg_count;
`endif

  int checks = 0;
  int errors = 0;

  sig_force_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

  sig_force #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .bus       (bus),
    .out_data  (out_data),
    .forced    (forced),
    .err       (err)
`ifdef SIG_FORCE_STATS_EN
    ,
    .chg_count (chg_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.frc_valid  = 1'b0;
    bus.frc_chan   = '0;
    bus.frc_value  = '0;
    bus.frc_cycles = '0;
    bus.rel_valid  = 1'b0;
    bus.rel_chan   = '0;
  endtask

  task automatic force_req(input int ch, input logic v, input int k);
    bus.frc_valid  = 1'b1;
    bus.frc_chan   = 3'(ch);
    bus.frc_value  = v;
    bus.frc_cycles = 8'(k);
  endtask

  initial begin
    idle_bus();
    rst     = 1'b1;
    in_data = 4'b1010;
    #1;
    chk("ready_in_reset", 32'(bus.frc_ready), 32'd0);
    tick();
    chk("rst_out", 32'(out_data), 32'h0);
    chk("rst_forced", 32'(forced), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // pass-through, one cycle latency
    rst     = 1'b0;
    in_data = 4'b0101;
    tick();
    chk("pass_a", 32'(out_data), 32'h5);
    in_data = 4'b1010;
    chk("pass_hold", 32'(out_data), 32'h5);
    tick();
    chk("pass_b", 32'(out_data), 32'hA);
    chk("pass_forced", 32'(forced), 32'h0);
    chk("ready_idle", 32'(bus.frc_ready), 32'd1);

    // timed force: chan 2, value 1, 3 cycles
    in_data = 4'b0000;
    force_req(2, 1'b1, 3);
    tick();
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      chk("timed_out", 32'(out_data), (i < 3) ? 32'h4 : 32'h0);
      chk("timed_forced", 32'(forced), (i < 3) ? 32'h4 : 32'h0);
      tick();
    end

    // hold on chan 0 for 20 cycles then release
    force_req(0, 1'b1, 0);
    tick();
    idle_bus();
    for (int i = 0; i < 20; i++) begin
      chk("hold_out", 32'(out_data), 32'h1);
      if (i < 19) tick();
    end
    in_data        = 4'b0010;
    bus.rel_valid  = 1'b1;
    bus.rel_chan   = 3'd0;
    tick();
    idle_bus();
    chk("release_out", 32'(out_data), 32'h2);
    chk("release_forced", 32'(forced), 32'h0);

    // collision on chan 1: release wins
    in_data       = 4'b0000;
    force_req(1, 1'b1, 0);
    bus.rel_valid = 1'b1;
    bus.rel_chan  = 3'd1;
    #1;
    chk("collide_ready", 32'(bus.frc_ready), 32'd0);
    tick();
    idle_bus();
    chk("collide_forced", 32'(forced), 32'h0);
    chk("collide_out", 32'(out_data), 32'h0);

    // force chan 3 while releasing chan 2 in the same cycle
    force_req(2, 1'b1, 0);
    tick();
    chk("pre_same_forced", 32'(forced), 32'h4);
    force_req(3, 1'b1, 0);
    bus.rel_valid = 1'b1;
    bus.rel_chan  = 3'd2;
    #1;
    chk("same_ready", 32'(bus.frc_ready), 32'd1);
    tick();
    idle_bus();
    chk("same_forced", 32'(forced), 32'h8);
    chk("same_out", 32'(out_data), 32'h8);
    bus.rel_valid = 1'b1;
    bus.rel_chan  = 3'd3;
    tick();
    idle_bus();
    chk("rel3_forced", 32'(forced), 32'h0);

    // re-force replaces the counter; K=1 lasts exactly one cycle
    force_req(1, 1'b1, 5);
    tick();
    force_req(1, 1'b1, 1);
    tick();
    idle_bus();
    chk("reload_forced", 32'(forced), 32'h2);
    tick();
    chk("reload_done", 32'(forced), 32'h0);
    chk("reload_out", 32'(out_data), 32'h0);
    chk("no_err_yet", 32'(err), 32'h0);

    // out-of-range force index
    in_data = 4'b0110;
    force_req(5, 1'b1, 0);
    tick();
    idle_bus();
    chk("bad_idx_err", 32'(err), 32'h1);
    chk("bad_idx_forced", 32'(forced), 32'h0);
    chk("bad_idx_out", 32'(out_data), 32'h6);
    tick();
    chk("err_sticky", 32'(err), 32'h1);

    // reset aborts a timed force
    force_req(1, 1'b0, 10);
    tick();
    idle_bus();
    chk("timed_pre_rst", 32'(forced), 32'h2);
    chk("timed_pre_rst_out", 32'(out_data), 32'h4);
    rst = 1'b1;
    tick();
    chk("mid_rst_forced", 32'(forced), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_out", 32'(out_data), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_out", 32'(out_data), 32'h6);
    chk("post_rst_forced", 32'(forced), 32'h0);

    // releasing an idle channel is a no-op; an out-of-range release sets err
    bus.rel_valid = 1'b1;
    bus.rel_chan  = 3'd0;
    tick();
    chk("rel_idle_out", 32'(out_data), 32'h6);
    chk("rel_idle_err", 32'(err), 32'h0);
    bus.rel_chan = 3'd4;
    tick();
    idle_bus();
    chk("rel_bad_err", 32'(err), 32'h1);

`ifdef SIG_FORCE_STATS_EN
    rst     = 1'b1;
    in_data = 4'b0000;
    tick();
    chk("stat_rst", 32'(chg_count[3*16 +: 16]), 32'd0);
    rst = 1'b0;
    tick();
    in_data = 4'b1000;
    tick();
    in_data = 4'b0000;
    tick();
    in_data = 4'b1000;
    tick();
    tick();
    chk("stat_ch3", 32'(chg_count[3*16 +: 16]), 32'd3);
    chk("stat_ch0", 32'(chg_count[0 +: 16]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_force.md
SIG_FORCE -- requirements
Module: sig_force

Interface
REQ-001 Parameter WIDTH, default 1, bits per channel.
REQ-002 Parameter CHANNELS, default 4, number of independent channels, range 2..16.
REQ-003 Parameter CNT_W, default 8, width of the force-duration counter.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in_data  input  CHANNELS*WIDTH  live channel inputs; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 frc_valid  input  1  force request present.
REQ-008 frc_ready  output  1  force request acceptable this cycle (combinational).
REQ-009 frc_chan  input  $clog2(CHANNELS)+1  target channel index.
REQ-010 frc_value  input  WIDTH  value to drive on the target channel.
REQ-011 frc_cycles  input  CNT_W  force duration in cycles; 0 means hold until released.
REQ-012 rel_valid  input  1  release request; always accepted.
REQ-013 rel_chan  input  $clog2(CHANNELS)+1  channel to release.
REQ-014 out_data  output  CHANNELS*WIDTH  registered per-channel output, forced or pass-through.
REQ-015 forced  output  CHANNELS  per-channel flag: channel is in a forced state.
REQ-016 err  output  1  sticky flag: out-of-range channel index seen on an accepted force or any release.

Function
REQ-017 Each channel SHALL hold one of three states: IDLE, TIMED, HOLD.
REQ-018 Force accept = frc_valid && frc_ready at a clock edge.
REQ-019 frc_ready SHALL be 1, except 0 when rel_valid=1 and rel_chan==frc_chan; release wins and the force is not accepted.
REQ-020 Accept with frc_cycles=K>0: channel -> TIMED, counter <= K; accept with K=0: channel -> HOLD.
REQ-021 An accept to an already TIMED or HOLD channel SHALL replace the value and reload the counter or state; there is no queuing.
REQ-022 TIMED: counter decrements each edge; at the edge where counter==1, channel -> IDLE.
REQ-023 out_data[c] SHALL be registered from the next state of channel c: the forced value if the next state is TIMED or HOLD, otherwise in_data[c].
REQ-024 Timing consequence of REQ-023: the forced value appears at the accept edge and lasts exactly K cycles for TIMED.
REQ-025 Pass-through latency SHALL be 1 cycle.
REQ-026 Release: channel -> IDLE at that edge, and out_data[c] <= in_data[c] at the same edge.
REQ-027 A release of an IDLE channel SHALL be a no-op.
REQ-028 Force and release on different channels in the same cycle SHALL both take effect.
REQ-029 Index >= CHANNELS: accepted or ignored with no channel change; err <= 1.
REQ-030 forced[c] SHALL equal (state != IDLE) and be registered alongside out_data.
REQ-031 in_data SHALL never be modified by the block; a force affects only out_data.

Reset
REQ-032 While rst=1: all channels IDLE, counters 0, out_data 0, forced 0, err 0.
REQ-033 A reset mid-force SHALL abort the force; the first edge after reset deasserts passes through in_data.
REQ-034 frc_ready SHALL be 0 while rst=1.

Configuration
REQ-035 Macro SIG_FORCE_STATS_EN compiles in the statistics feature.
REQ-036 With SIG_FORCE_STATS_EN defined: output chg_count, CHANNELS*16 bits.
REQ-037 chg_count holds per-channel saturating counts (max 16'hFFFF) of edges where out_data[c] changed value.
REQ-038 chg_count SHALL be cleared by rst.
REQ-039 Without SIG_FORCE_STATS_EN: the chg_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-040 Package sig_force_pkg SHALL hold the state enum (IDLE, TIMED, HOLD) and the constant STAT_W=16.
REQ-041 Sub-module sig_force_chan (one per channel, generate loop) SHALL hold the per-channel state, counter, and output register.
REQ-042 The top level SHALL contain request decode, the release-wins arbitration, and err.

Verification
REQ-043 Pass-through: CHANNELS=4, WIDTH=1; in_data toggles, no requests -> out_data follows in_data one cycle later; forced=0.
REQ-044 Timed force: chan 2, value 1, cycles 3, in_data[2]=0 -> out_data[2]=1 for exactly 3 cycles, then 0; forced[2] is high for the same 3 cycles.
REQ-045 Hold and release: chan 0, cycles 0, value 1 for 20 cycles, then release chan 0 -> out_data[0]=1 throughout the 20 cycles, then in_data[0] on the release edge.
REQ-046 Collision: force and release both on chan 1 in one cycle -> frc_ready=0; chan 1 stays IDLE.
REQ-047 Same-cycle different channels: force chan 3 with release chan 2 -> both take effect.
REQ-048 Reset and error: index 5 force -> err=1, no channel changes; rst during a TIMED force -> forced=0, err=0.
REQ-049 With SIG_FORCE_STATS_EN defined: 3 output toggles -> chg_count for that channel = 3.
